// File: rtl/scan_sequencer.sv
// Raster scan sequencer: emits each (line, pixel) coordinate of a
// HEIGHT x WIDTH frame once in raster order, with stall bubbles,
// back-to-back frames and abort, then drains a LATENCY-deep pipeline
// before pulsing done.
module scan_sequencer #(
    parameter int HEIGHT  = 480,
    parameter int WIDTH   = 640,
    parameter int LATENCY = 4,
    localparam int V_BITW = $clog2(HEIGHT),
    localparam int H_BITW = $clog2(WIDTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              continuous,
    input  logic              abort,
    output logic              out_valid,
    output logic              out_fstart,
    output logic [V_BITW-1:0] out_vcnt,
    output logic [H_BITW-1:0] out_hcnt,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

    // LATENCY+1 keeps the counter at least one bit wide when LATENCY == 1
    localparam int D_BITW = $clog2(LATENCY + 1);
    localparam logic [V_BITW-1:0] V_LAST = V_BITW'(HEIGHT - 1);
    localparam logic [H_BITW-1:0] H_LAST = H_BITW'(WIDTH - 1);
    localparam logic [D_BITW-1:0] D_LOAD = D_BITW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [D_BITW-1:0]   dcnt, dcnt_nxt;
    logic                valid_nxt, fstart_nxt, done_nxt;
    logic [V_BITW-1:0]   vcnt_nxt;
    logic [H_BITW-1:0]   hcnt_nxt;
    logic [15:0]         fcnt_nxt;

    // State, drain counter and every output are registered together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dcnt       <= '0;
            out_valid  <= 1'b0;
            out_fstart <= 1'b0;
            out_vcnt   <= '0;
            out_hcnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            dcnt       <= dcnt_nxt;
            out_valid  <= valid_nxt;
            out_fstart <= fstart_nxt;
            out_vcnt   <= vcnt_nxt;
            out_hcnt   <= hcnt_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            frame_cnt  <= fcnt_nxt;
        end
    end

    // Next state and next outputs; the current coordinate is the one last
    // emitted, so a stalled edge simply holds it and the next edge advances
    always_comb begin
        state_nxt  = state;
        dcnt_nxt   = dcnt;
        valid_nxt  = 1'b0;
        fstart_nxt = 1'b0;
        done_nxt   = 1'b0;
        vcnt_nxt   = out_vcnt;
        hcnt_nxt   = out_hcnt;
        fcnt_nxt   = frame_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = SCAN;
                    valid_nxt  = 1'b1;
                    fstart_nxt = 1'b1;
                    vcnt_nxt   = '0;
                    hcnt_nxt   = '0;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_nxt = DRAIN;
                    dcnt_nxt  = D_LOAD;
                end else if (!stall) begin
                    if (out_hcnt == H_LAST) begin
                        hcnt_nxt = '0;
                        if (out_vcnt == V_LAST) begin
                            vcnt_nxt = '0;
                            fcnt_nxt = frame_cnt + 16'd1;
                            if (continuous) begin
                                valid_nxt  = 1'b1;
                                fstart_nxt = 1'b1;
                            end else begin
                                state_nxt = DRAIN;
                                dcnt_nxt  = D_LOAD;
                            end
                        end else begin
                            vcnt_nxt  = out_vcnt + 1'b1;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        hcnt_nxt  = out_hcnt + 1'b1;
                        valid_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (dcnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    dcnt_nxt = dcnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
